// File: rtl/servo_move_sequencer_if.sv
// Command handshake plus servo-side outputs of the move sequencer.
// master drives commands and abort; slave is the sequencer.
interface servo_move_sequencer_if #(
   parameter int DUR_W      = 12,
   parameter int FIFO_DEPTH = 4
);
   logic                          cmd_valid;
   logic [2:0]                    cmd_dir;
   logic [DUR_W-1:0]              cmd_dur;
   logic                          cmd_ready;
   logic                          abort;
   logic [2:0]                    direction;
   logic                          use_servo;
   logic                          busy;
   logic                          move_done;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (
      output cmd_valid, cmd_dir, cmd_dur, abort,
      input  cmd_ready, direction, use_servo, busy, move_done, fifo_count
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_dur, abort,
      output cmd_ready, direction, use_servo, busy, move_done, fifo_count
   );
endinterface

// File: rtl/servo_move_sequencer.sv
// Buffers timed motion commands and replays each as a held direction with a load strobe, then a stop gap.
// Latency: first strobe one cycle after acceptance; backpressure: cmd_ready drops when the FIFO is full or abort is held.
module servo_move_sequencer #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int FIFO_DEPTH  = 4,
   parameter int DUR_W       = 12,
   parameter int GAP_MS      = 50
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   servo_move_sequencer_if.slave io_seq
);
   localparam int     TICKS   = CLK_FREQ_HZ / 1000;
   localparam int     AW      = $clog2(FIFO_DEPTH);
   localparam int     CW      = AW + 1;
   localparam longint DUR_MAX = (longint'(1) <<< DUR_W) - 1;
   localparam longint MAX_MS  = (DUR_MAX > longint'(GAP_MS)) ? DUR_MAX : longint'(GAP_MS);
   localparam longint MAX_T   = MAX_MS * longint'(TICKS);
   localparam int     TW      = $clog2(MAX_T + 1);

   localparam logic [TW-1:0] TICKS_T  = TW'(TICKS);
   localparam logic [TW-1:0] GAP_LOAD = TW'(longint'(GAP_MS) * longint'(TICKS) - 1);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_GAP} state_t;

   typedef struct packed {
      logic [2:0]       dir;
      logic [DUR_W-1:0] dur;
   } cmd_t;

   logic [1:0]    r_rst_sync;
   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_dir;
   logic          r_use;
   logic          r_done;
   cmd_t          r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   state_t        w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic [2:0]    w_dir_nxt;
   logic          w_use_nxt;
   logic          w_done_nxt;
   logic          w_pop;
   logic          w_flush;
   logic          w_rst_ok;
   logic          w_ready;
   logic          w_push;
   cmd_t          w_cmd;
   cmd_t          w_head;

   // Reset release is re-timed so every flop leaves reset on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rst_sync <= '0;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_ok = r_rst_sync[1];
   assign w_ready  = w_rst_ok & (r_count < CW'(FIFO_DEPTH)) & ~io_seq.abort;
   assign w_push   = io_seq.cmd_valid & w_ready;
   assign w_cmd    = '{dir: io_seq.cmd_dir, dur: io_seq.cmd_dur};
   assign w_head   = r_mem[r_rptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_dir_nxt   = r_dir;
      w_use_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      if (!w_rst_ok) begin
         w_state_nxt = S_IDLE;
      end else if (io_seq.abort) begin
         w_flush     = 1'b1;
         w_state_nxt = S_IDLE;
         w_timer_nxt = '0;
         if (r_dir != 3'b000) begin
            w_dir_nxt = 3'b000;
            w_use_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  w_pop = 1'b1;
                  if (w_head.dur != '0) begin
                     w_dir_nxt   = w_head.dir;
                     w_use_nxt   = 1'b1;
                     w_timer_nxt = TW'(w_head.dur) * TICKS_T - TW'(1);
                     w_state_nxt = S_MOVE;
                  end else begin
                     w_done_nxt = 1'b1;
                  end
               end
            end
            S_MOVE: begin
               if (r_timer == '0) begin
                  w_dir_nxt  = 3'b000;
                  w_use_nxt  = 1'b1;
                  w_done_nxt = 1'b1;
                  if (GAP_MS > 0) begin
                     w_timer_nxt = GAP_LOAD;
                     w_state_nxt = S_GAP;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_timer_nxt = r_timer - 1'b1;
               end
            end
            S_GAP: begin
               if (r_timer == '0) w_state_nxt = S_IDLE;
               else               w_timer_nxt = r_timer - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_timer <= '0;
         r_dir   <= 3'b000;
         r_use   <= 1'b0;
         r_done  <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_timer <= w_timer_nxt;
         r_dir   <= w_dir_nxt;
         r_use   <= w_use_nxt;
         r_done  <= w_done_nxt;
         if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= w_cmd;
   end

   assign io_seq.cmd_ready  = w_ready;
   assign io_seq.direction  = r_dir;
   assign io_seq.use_servo  = r_use;
   assign io_seq.move_done  = r_done;
   assign io_seq.busy       = (r_state != S_IDLE) | (r_count != '0);
   assign io_seq.fifo_count = r_count;
endmodule

// File: tb/tb_servo_move_sequencer.sv
// Bench for servo_move_sequencer: directed and random command batches scored against an event-timeline model.
// Edges are numbered; expected strobes are placed on edges with plain move/gap arithmetic.
module tb_servo_move_sequencer;
   localparam int CLK_HZ = 10000;
   localparam int TICKS  = CLK_HZ / 1000;
   localparam int GAP    = 2 * TICKS;

   typedef struct packed {
      int         edge_n;
      logic       use_s;
      logic       done_s;
      logic [2:0] dir;
   } ev_t;

   typedef struct packed {
      logic [2:0]  dir;
      logic [11:0] dur;
      int          acc;
   } mcmd_t;

   logic clk;
   logic rst_n;
   int   edge_cnt = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   model_free = 0;
   ev_t   obs_q[$];
   ev_t   exp_q[$];
   mcmd_t cmd_q[$];

   servo_move_sequencer_if #(.DUR_W(12), .FIFO_DEPTH(4)) bus ();

   servo_move_sequencer #(
      .CLK_FREQ_HZ(CLK_HZ),
      .FIFO_DEPTH (4),
      .DUR_W      (12),
      .GAP_MS     (2)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_seq (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (bus.use_servo === 1'b1 || bus.move_done === 1'b1))
         obs_q.push_back('{edge_cnt, bus.use_servo, bus.move_done, bus.direction});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic push(input logic [2:0] d, input logic [11:0] du);
      bit ok;
      ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = d;
      bus.cmd_dur   = du;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (bus.cmd_ready === 1'b1) begin
            cmd_q.push_back('{d, du, edge_cnt + 1});
            ok = 1'b1;
         end
         @(negedge clk);
      end
      check("push_accepted", ok, 1);
   endtask

   task automatic idle(input int n);
      bus.cmd_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Each command pops on the first free IDLE edge after acceptance;
   // a move ends dur*TICKS edges later, and the gap plus one IDLE edge follow.
   task automatic build_expected(output int idle_edge);
      int p;
      int e;
      idle_edge = model_free;
      foreach (cmd_q[i]) begin
         p = (cmd_q[i].acc + 1 > model_free) ? cmd_q[i].acc + 1 : model_free;
         if (cmd_q[i].dur == 12'd0) begin
            exp_q.push_back('{p, 1'b0, 1'b1, 3'b000});
            model_free = p + 1;
            idle_edge  = p;
         end else begin
            e = p + int'(cmd_q[i].dur) * TICKS;
            exp_q.push_back('{p, 1'b1, 1'b0, cmd_q[i].dir});
            exp_q.push_back('{e, 1'b1, 1'b1, 3'b000});
            model_free = e + GAP + 1;
            idle_edge  = e + GAP;
         end
      end
      cmd_q.delete();
   endtask

   task automatic compare_events(input string tag);
      check($sformatf("%s_events", tag), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s_ev%0d_edge", tag, i), obs_q[i].edge_n, exp_q[i].edge_n);
         check($sformatf("%s_ev%0d_use", tag, i), obs_q[i].use_s, exp_q[i].use_s);
         check($sformatf("%s_ev%0d_done", tag, i), obs_q[i].done_s, exp_q[i].done_s);
         check($sformatf("%s_ev%0d_dir", tag, i), obs_q[i].dir, exp_q[i].dir);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic finish_batch(input string tag);
      int idle_edge;
      int low_edge;
      bus.cmd_valid = 1'b0;
      build_expected(idle_edge);
      low_edge = -1;
      for (int k = 0; k < 4000; k++) begin
         if (bus.busy === 1'b0) begin
            low_edge = edge_cnt;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_busy_fall"}, low_edge, idle_edge);
      repeat (3) @(negedge clk);
      compare_events(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dir"},   bus.direction, 3'b000);
      check({tag, "_use"},   bus.use_servo, 1'b0);
      check({tag, "_busy"},  bus.busy, 1'b0);
      check({tag, "_count"}, bus.fifo_count, 3'd0);
      check({tag, "_ready"}, bus.cmd_ready, 1'b0);
      check({tag, "_done"},  bus.move_done, 1'b0);
   endtask

   task automatic release_reset(input string tag);
      bit seen;
      seen = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 3 && !seen; k++) begin
         @(negedge clk);
         if (bus.cmd_ready === 1'b1) seen = 1'b1;
      end
      check({tag, "_ready_within3"}, seen, 1'b1);
      obs_q.delete();
      cmd_q.delete();
      model_free = edge_cnt;
   endtask

   initial begin
      int ab_edge;
      int a0;
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = 3'b000;
      bus.cmd_dur   = 12'd0;
      bus.abort     = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      release_reset("por");

      push(3'b001, 12'd3);
      finish_batch("single");

      push(3'b011, 12'd1);
      push(3'b100, 12'd2);
      push(3'b010, 12'd1);
      finish_batch("b2b");

      push(3'b001, 12'd0);
      push(3'b010, 12'd1);
      finish_batch("zero_dur");

      push(3'b001, 12'd3);
      push(3'b010, 12'd1);
      push(3'b011, 12'd2);
      push(3'b100, 12'd1);
      push(3'b111, 12'd1);
      check("full_count", bus.fifo_count, 3'd4);
      check("full_ready", bus.cmd_ready, 1'b0);
      push(3'b101, 12'd1);
      finish_batch("fifo_full");

      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(5, 1);
         for (int i = 0; i < n; i++) begin
            push(3'($urandom_range(7, 0)), 12'($urandom_range(3, 0)));
            idle($urandom_range(2, 0));
         end
         finish_batch($sformatf("rand%0d", r));
      end

      push(3'b001, 12'd5);
      a0 = cmd_q[0].acc;
      push(3'b010, 12'd1);
      push(3'b011, 12'd1);
      idle(15);
      bus.abort = 1'b1;
      ab_edge = edge_cnt + 1;
      @(negedge clk);
      check("abort_dir",   bus.direction, 3'b000);
      check("abort_use",   bus.use_servo, 1'b1);
      check("abort_count", bus.fifo_count, 3'd0);
      check("abort_done",  bus.move_done, 1'b0);
      check("abort_ready", bus.cmd_ready, 1'b0);
      bus.abort = 1'b0;
      idle(100);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_events", obs_q.size(), 2);
      if (obs_q.size() >= 2) begin
         check("abort_start_edge", obs_q[0].edge_n, a0 + 1);
         check("abort_start_dir",  obs_q[0].dir, 3'b001);
         check("abort_stop_edge",  obs_q[1].edge_n, ab_edge);
         check("abort_stop_done",  obs_q[1].done_s, 1'b0);
         check("abort_stop_dir",   obs_q[1].dir, 3'b000);
      end
      obs_q.delete();
      cmd_q.delete();
      model_free = edge_cnt;

      bus.abort = 1'b1;
      @(negedge clk);
      check("abort_idle_use", bus.use_servo, 1'b0);
      check("abort_idle_dir", bus.direction, 3'b000);
      bus.abort = 1'b0;
      @(negedge clk);
      check("abort_idle_ready", bus.cmd_ready, 1'b1);

      push(3'b100, 12'd3);
      idle(10);
      check("pre_rst_dir", bus.direction, 3'b100);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      repeat (3) @(negedge clk);
      release_reset("mid_rst");
      idle(5);
      check("post_rst_events", obs_q.size(), 0);

      push(3'b010, 12'd1);
      finish_batch("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
